// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Owns the single shared main-memory port on behalf of the I-cache and the
// D-cache. Arbitrates D-side write-through stores, D-cache misses and I-cache
// misses, sequences each 8-word block fill through the pipelined memory, and
// drives the data/tag write enables of whichever cache is being filled.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_miss / i_miss_addr          I-cache miss request (level) and byte address
//   d_miss / d_miss_addr          D-cache miss request (level) and byte address
//   d_wr_req/d_wr_addr/d_wr_data  D-side write-through store request (level)
//   mem_valid / mem_rdata         read data returning from memory
//   mem_en/mem_wr/mem_addr/mem_wdata  memory request port
//   i_data_we / i_tag_we          I-cache data / tag array write enables
//   d_data_we / d_tag_we          D-cache data / tag array write enables
//   fill_addr / fill_data         address and word written into the cache
//   d_wr_ack                      one-cycle pulse when the store is issued
//   busy                          high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        i_data_we,
    output logic        i_tag_we,
    output logic        d_data_we,
    output logic        d_tag_we,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        d_wr_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL_I,
        FILL_D
    } state_t;

    localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);

    state_t      state;
    logic [15:0] base;
    logic [2:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic [2:0]  next_issue;
    logic        last_i;
    logic        filling;
    logic        receiving;
    logic        last_word;
    logic [15:0] recv_addr;
    logic        unused_lat;

    // The fill sequencing counts returning mem_valid pulses rather than
    // cycles, so the memory latency only documents the expected timing.
    assign unused_lat = (MEM_LAT > 0);

    assign filling    = (state == FILL_I) || (state == FILL_D);
    assign receiving  = filling && mem_valid;
    assign last_word  = receiving && (recv_cnt == LAST_WORD);
    assign recv_addr  = base + {12'd0, recv_cnt, 1'b0};
    assign next_issue = issue_cnt + 3'd1;

    // Single FSM: arbitration in IDLE, one-cycle store in WRITE, and the
    // read-issue / read-receive sequencing of a block fill. The memory port
    // outputs are registered and return to zero unless a request is being
    // issued in the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            last_i    <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            d_wr_ack  <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            d_wr_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    // Stores win outright; on a miss tie the cache that was
                    // not filled last goes first.
                    if (d_wr_req) begin
                        state     <= WRITE;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= d_wr_addr;
                        mem_wdata <= d_wr_data;
                        d_wr_ack  <= 1'b1;
                    end else if (d_miss && (!i_miss || last_i)) begin
                        state     <= FILL_D;
                        last_i    <= 1'b0;
                        base      <= d_miss_addr & 16'hFFF0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        mem_en    <= 1'b1;
                        mem_addr  <= d_miss_addr & 16'hFFF0;
                    end else if (i_miss) begin
                        state     <= FILL_I;
                        last_i    <= 1'b1;
                        base      <= i_miss_addr & 16'hFFF0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        mem_en    <= 1'b1;
                        mem_addr  <= i_miss_addr & 16'hFFF0;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                FILL_I, FILL_D: begin
                    // mem_en doubles as "issue still in progress": once the
                    // last word has gone out it stays low and issue_cnt
                    // holds at the final index.
                    if (mem_en && (issue_cnt != LAST_WORD)) begin
                        issue_cnt <= next_issue;
                        mem_en    <= 1'b1;
                        mem_addr  <= base + {12'd0, next_issue, 1'b0};
                    end
                    if (mem_valid) begin
                        recv_cnt <= recv_cnt + 3'd1;
                        if (recv_cnt == LAST_WORD) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Cache write side follows mem_valid in the same cycle, so it is decoded
    // from the registered state; IDLE/WRITE (and reset) force it to zero.
    assign i_data_we = receiving && (state == FILL_I);
    assign i_tag_we  = last_word && (state == FILL_I);
    assign d_data_we = receiving && (state == FILL_D);
    assign d_tag_we  = last_word && (state == FILL_D);
    assign fill_addr = receiving ? recv_addr : '0;
    assign fill_data = receiving ? mem_rdata : '0;
    assign busy      = (state != IDLE);

endmodule
